// File: rtl/alu_mdu.sv
`default_nettype none
// alu_mdu: registered MIPS-style ALU with start/valid handshake and an iterative
// multiply/divide unit (enabled by ALU_MDU_MULDIV_EN) writing HI/LO. Revision 1.0
module alu_mdu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [4:0]       aluControl,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [4:0] OP_AND  = 5'b00000, OP_OR   = 5'b00001, OP_ADD  = 5'b00010,
                          OP_XOR  = 5'b00011, OP_SUB  = 5'b00110, OP_SLT  = 5'b00111,
                          OP_SLL  = 5'b01000, OP_SRL  = 5'b01001, OP_SRA  = 5'b01010,
                          OP_SLTU = 5'b01011, OP_NOR  = 5'b01100, OP_MULT = 5'b10000,
                          OP_MULTU= 5'b10001, OP_DIV  = 5'b10010, OP_DIVU = 5'b10011,
                          OP_MFHI = 5'b10100, OP_MFLO = 5'b10101, OP_MTHI = 5'b10110,
                          OP_MTLO = 5'b10111;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d, lo_q, lo_d;
   logic             zero_q, zero_d, ovf_q, ovf_d, valid_q, valid_d;
   logic [WIDTH-1:0] sum, diff, alu_res;
   logic [SHW-1:0]   shamt;
   logic             alu_ovf, accept, single_op;

   assign accept   = start && ready;
   assign shamt    = data1[SHW-1:0];
   assign valid    = valid_q;
   assign out      = out_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

`ifdef ALU_MDU_MULDIV_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_e;
   state_e             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d, a_q, a_d;
   logic               div_q, div_d, negq_q, negq_d, negr_q, negr_d;
   logic               dz_q, dz_d, dovf_q, dovf_d;
   logic               sgn, neg_a, neg_b;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     shifted, trial, psum;
   logic [2*WIDTH-1:0] prod;

   assign ready     = (state_q == S_IDLE);
   assign single_op = (aluControl[4:2] != 3'b100);
`else
   assign ready     = 1'b1;
   assign single_op = 1'b1;
`endif

   always_comb begin
      sum     = data1 + data2;
      diff    = data1 - data2;
      alu_res = '0;
      alu_ovf = 1'b0;
      case (aluControl)
         OP_AND:  alu_res = data1 & data2;
         OP_OR:   alu_res = data1 | data2;
         OP_XOR:  alu_res = data1 ^ data2;
         OP_NOR:  alu_res = ~(data1 | data2);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
         end
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
         OP_SLL:  alu_res = data2 << shamt;
         OP_SRL:  alu_res = data2 >> shamt;
         OP_SRA:  alu_res = $signed(data2) >>> shamt;
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         OP_MTHI, OP_MTLO: alu_res = data1;
`ifndef ALU_MDU_MULDIV_EN
         // Without the mul/div unit these codes are flagged as unimplemented.
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_ovf = 1'b1;
`endif
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      out_d   = out_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (accept && single_op) begin
         out_d   = alu_res;
         zero_d  = (alu_res == '0);
         ovf_d   = alu_ovf;
         valid_d = 1'b1;
         if (aluControl == OP_MTHI) hi_d = data1;
         if (aluControl == OP_MTLO) lo_d = data1;
      end
`ifdef ALU_MDU_MULDIV_EN
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      b_d      = b_q;
      a_d      = a_q;
      div_d    = div_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      dz_d     = dz_q;
      dovf_d   = dovf_q;
      sgn      = !aluControl[0];
      neg_a    = sgn && data1[WIDTH-1];
      neg_b    = sgn && data2[WIDTH-1];
      a_mag    = neg_a ? -data1 : data1;
      b_mag    = neg_b ? -data2 : data2;
      shifted  = {acc_hi_q, acc_lo_q[WIDTH-1]};
      trial    = shifted - {1'b0, b_q};
      psum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      prod     = {acc_hi_q, acc_lo_q};
      case (state_q)
         S_IDLE: if (accept && !single_op) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = a_mag;
            b_d      = b_mag;
            a_d      = data1;
            div_d    = aluControl[1];
            negq_d   = neg_a ^ neg_b;
            negr_d   = neg_a;
            dz_d     = (data2 == '0);
            dovf_d   = sgn && (data1 == MIN_VAL) && (data2 == '1);
         end
         S_RUN: begin
            // acc_hi/acc_lo hold product high/low for MULT, remainder/quotient for DIV.
            if (div_q) begin
               if (!trial[WIDTH]) begin
                  acc_hi_d = trial[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi_d = shifted[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               {acc_hi_d, acc_lo_d} = {psum, acc_lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
            ovf_d = 1'b0;
            if (!div_q) begin
               if (negq_q) prod = -prod;
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else if (dz_q) begin
               hi_d  = a_q;
               lo_d  = '1;
               ovf_d = 1'b1;
            end else if (dovf_q) begin
               hi_d  = '0;
               lo_d  = MIN_VAL;
               ovf_d = 1'b1;
            end else begin
               hi_d = negr_q ? -acc_hi_q : acc_hi_q;
               lo_d = negq_q ? -acc_lo_q : acc_lo_q;
            end
            out_d   = lo_d;
            zero_d  = (lo_d == '0);
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef ALU_MDU_MULDIV_EN
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         b_q      <= '0;
         a_q      <= '0;
         div_q    <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         dz_q     <= 1'b0;
         dovf_q   <= 1'b0;
`endif
      end else begin
         out_q    <= out_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef ALU_MDU_MULDIV_EN
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         b_q      <= b_d;
         a_q      <= a_d;
         div_q    <= div_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         dz_q     <= dz_d;
         dovf_q   <= dovf_d;
`endif
      end
   end
endmodule
`default_nettype wire
